// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RISC-V control FSM:
// state encodings, opcodes, datapath select encodings and ALU operation codes.
package mc_pkg;

    // 4-bit state encoding for the control FSM
    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_JALR     = 4'd11;

    // RV32I opcodes handled by this controller
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Branch flavours distinguished by funct3
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // ALU operation codes seen by the datapath ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // True for every opcode the FSM knows how to sequence
    function automatic logic is_supported_op(input logic [6:0] opc);
        return (opc == OP_LOAD)   || (opc == OP_STORE) ||
               (opc == OP_RTYPE)  || (opc == OP_ITYPE) ||
               (opc == OP_BRANCH) || (opc == OP_JAL)   ||
               (opc == OP_JALR);
    endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: turns the FSM's ALUOp plus funct3/funct7_5 into the ALU
// operation code. funct7_5 is expected to be pre-qualified as "R-type sub".
module aludec
    import mc_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] ALUControl
);

    // Select add/sub directly, otherwise decode the instruction's funct3
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b001:  ALUControl = ALU_SLL;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b011:  ALUControl = ALU_SLT;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b101:  ALUControl = ALU_SRL;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM for a shared-memory, single-ALU datapath.
// Sequences lw, sw, R-type, I-type ALU, beq, bne, jal and jalr, stalling in
// FETCH/MEMREAD/MEMWRITE until the memory signals ready.
// Optional build macro: MCCTRL_PERF_EN adds cycle_cnt and instret_cnt outputs.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_instr
`ifdef MCCTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] aluOp;
    logic       rTypeSub;
    logic [2:0] aluControlRaw;

    // State register; reset always lands in FETCH, aborting any instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory states hold until mem_ready is sampled high
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JALR:     state_d = S_JAL;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state datapath controls; everything is forced low while rst is high
    always_comb begin
        mem_req       = 1'b0;
        MemWrite      = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        aluOp         = ALUOP_ADD;
        illegal_instr = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA       = SRCA_OLDPC;
                ALUSrcB       = SRCB_IMM;
                illegal_instr = !is_supported_op(op);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                aluOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                aluOp     = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                PCWrite   = ((funct3 == F3_BEQ) &&  Zero) ||
                            ((funct3 == F3_BNE) && !Zero);
            end
            S_JALR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
        if (rst) begin
            mem_req       = 1'b0;
            MemWrite      = 1'b0;
            AdrSrc        = 1'b0;
            IRWrite       = 1'b0;
            PCWrite       = 1'b0;
            RegWrite      = 1'b0;
            ResultSrc     = 2'b00;
            ALUSrcA       = 2'b00;
            ALUSrcB       = 2'b00;
            aluOp         = ALUOP_ADD;
            illegal_instr = 1'b0;
        end
    end

    // Immediate format follows the opcode directly, independent of state
    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
        if (rst) begin
            ImmSrc = 2'b00;
        end
    end

    // funct7_5 only selects subtract for register-register ops (addi has imm bit 30)
    assign rTypeSub   = funct7_5 && (op == OP_RTYPE);
    assign ALUControl = rst ? 3'b000 : aluControlRaw;

    aludec u_aludec (
        .ALUOp      (aluOp),
        .funct3     (funct3),
        .funct7_5   (rTypeSub),
        .ALUControl (aluControlRaw)
    );

`ifdef MCCTRL_PERF_EN
    logic [31:0] cycleCnt_q;
    logic [31:0] instretCnt_q;
    logic        retire;

    // An instruction retires when its final state hands back to FETCH
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                     (state_q == S_ALUWB) || (state_q == S_BRANCH));

    // Free-running cycle and retired-instruction counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            cycleCnt_q   <= 32'd0;
            instretCnt_q <= 32'd0;
        end else begin
            cycleCnt_q   <= cycleCnt_q + 32'd1;
            instretCnt_q <= instretCnt_q + {31'd0, retire};
        end
    end

    assign cycle_cnt   = cycleCnt_q;
    assign instret_cnt = instretCnt_q;
`endif

endmodule
